axi2per_r_fifo: RTL and testbench

- Parametrised, multi-entry elastic buffer for the AXI read-data (R) channel on the peripheral-to-AXI return path of the axi2per bridge.
- Stores whole R beats (id, user, data, resp, last) in a DEPTH-entry ring buffer.
- Offers an optional zero-latency fall-through mode.
- Reports fill level and the number of complete bursts held, so upstream logic can throttle and downstream arbitration can favour whole bursts.

---
 rtl/axi2per_pkg.sv | 19 +
 rtl/axi2per_fifo.sv | 70 +++++++
 rtl/axi2per_r_fifo.sv | 95 +++++++++
 tb/tb_axi2per_r_fifo.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2per_pkg.sv
// Shared definitions for the axi2per bridge: R beat sizing and AXI response codes.
package axi2per_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // One R beat = id + user + data + resp(2) + last(1).
    function automatic int r_beat_width(input int id_width, input int data_width, input int user_width);
        return 3 + id_width + data_width + user_width;
    endfunction

    // SLVERR and DECERR both have resp[1] set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi2per_fifo.sv
// Generic valid/ready ring-buffer FIFO with level output and optional fall-through.
module axi2per_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] level,
    output logic                 wr_en,
    output logic                 rd_en
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_WIDTH-1:0] level_reg;
    logic                 empty;
    logic                 full;
    logic                 bypass;

    assign empty    = (level_reg == '0);
    assign full     = (level_reg == CNT_WIDTH'(DEPTH));
    assign in_ready = !full;
    assign bypass   = FALL_THROUGH && empty;

    assign out_valid = bypass ? in_valid : !empty;
    assign out_data  = bypass ? in_data  : mem[rd_ptr_reg];

    // A beat consumed in the same cycle it arrives at an empty fall-through FIFO is never stored.
    assign wr_en = in_valid && in_ready && !(bypass && out_ready);
    assign rd_en = out_valid && out_ready && !empty;
    assign level = level_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_reg <= level_reg + CNT_WIDTH'(1);
                2'b01:   level_reg <= level_reg - CNT_WIDTH'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: rtl/axi2per_r_fifo.sv
// AXI R-channel elastic buffer: stores whole beats, counts complete bursts, flags popped error responses.
module axi2per_r_fifo
    import axi2per_pkg::*;
#(
    parameter int ID_WIDTH     = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 6,
    parameter int DEPTH        = 4,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [1:0]            slave_resp_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,
    output logic [CNT_WIDTH-1:0]  level_o,
    output logic [CNT_WIDTH-1:0]  bursts_o,
    output logic                  err_seen_o
);

    localparam int BEAT_W = r_beat_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

    logic [BEAT_W-1:0]    beat_in;
    logic [BEAT_W-1:0]    beat_out;
    logic                 wr_en;
    logic                 rd_en;
    logic [CNT_WIDTH-1:0] bursts_reg;
    logic                 err_seen_reg;

    assign beat_in = {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};
    assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = beat_out;

    axi2per_fifo #(
        .WIDTH        (BEAT_W),
        .DEPTH        (DEPTH),
        .FALL_THROUGH (FALL_THROUGH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (slave_valid_i),
        .in_data   (beat_in),
        .in_ready  (slave_ready_o),
        .out_valid (master_valid_o),
        .out_data  (beat_out),
        .out_ready (master_ready_i),
        .level     (level_o),
        .wr_en     (wr_en),
        .rd_en     (rd_en)
    );

    // Only stored beats move the burst count; fall-through beats bypass it entirely.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bursts_reg   <= '0;
            err_seen_reg <= 1'b0;
        end else begin
            case ({wr_en && slave_last_i, rd_en && master_last_o})
                2'b10:   bursts_reg <= bursts_reg + CNT_WIDTH'(1);
                2'b01:   bursts_reg <= bursts_reg - CNT_WIDTH'(1);
                default: bursts_reg <= bursts_reg;
            endcase
            if (master_valid_o && master_ready_i && resp_is_err(master_resp_o)) begin
                err_seen_reg <= 1'b1;
            end
        end
    end

    assign bursts_o   = bursts_reg;
    assign err_seen_o = err_seen_reg;

`ifndef SYNTHESIS
    a_level_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        level_o <= CNT_WIDTH'(DEPTH));
    a_bursts_le_level: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bursts_o <= level_o);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_en && (level_o == CNT_WIDTH'(DEPTH))));
    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (master_valid_o && !master_ready_i) |=> (master_valid_o && $stable(beat_out)));
`endif

endmodule

// File: tb/tb_axi2per_r_fifo.sv
// Bench for axi2per_r_fifo: DEPTH=4 registered instance and DEPTH=3 fall-through instance, scoreboard-checked.
module tb_axi2per_r_fifo;
    import axi2per_pkg::*;

    typedef struct packed {
        logic [3:0]  id;
        logic [5:0]  user;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    beat_t b0, b1;
    logic  s_valid0, s_ready0, m_valid0, m_ready0;
    logic  s_valid1, s_ready1, m_valid1, m_ready1;
    logic [63:0] m_data0, m_data1;
    logic [1:0]  m_resp0, m_resp1;
    logic [5:0]  m_user0, m_user1;
    logic [3:0]  m_id0, m_id1;
    logic        m_last0, m_last1;
    logic [2:0]  level0, bursts0;
    logic [1:0]  level1, bursts1;
    logic        err0, err1;
    beat_t       act0, act1;
    beat_t       q0[$];
    beat_t       q1[$];

    assign act0 = {m_id0, m_user0, m_data0, m_resp0, m_last0};
    assign act1 = {m_id1, m_user1, m_data1, m_resp1, m_last1};

    axi2per_r_fifo #(.DEPTH(4), .FALL_THROUGH(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .slave_valid_i(s_valid0), .slave_data_i(b0.data), .slave_resp_i(b0.resp),
        .slave_user_i(b0.user), .slave_id_i(b0.id), .slave_last_i(b0.last),
        .slave_ready_o(s_ready0),
        .master_valid_o(m_valid0), .master_data_o(m_data0), .master_resp_o(m_resp0),
        .master_user_o(m_user0), .master_id_o(m_id0), .master_last_o(m_last0),
        .master_ready_i(m_ready0),
        .level_o(level0), .bursts_o(bursts0), .err_seen_o(err0)
    );

    axi2per_r_fifo #(.DEPTH(3), .FALL_THROUGH(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .slave_valid_i(s_valid1), .slave_data_i(b1.data), .slave_resp_i(b1.resp),
        .slave_user_i(b1.user), .slave_id_i(b1.id), .slave_last_i(b1.last),
        .slave_ready_o(s_ready1),
        .master_valid_o(m_valid1), .master_data_o(m_data1), .master_resp_o(m_resp1),
        .master_user_o(m_user1), .master_id_o(m_id1), .master_last_o(m_last1),
        .master_ready_i(m_ready1),
        .level_o(level1), .bursts_o(bursts1), .err_seen_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(input logic [3:0] id, input logic [63:0] data,
                                 input logic [1:0] resp, input logic last);
        beat_t b;
        b.id   = id;
        b.user = data[5:0];
        b.data = data;
        b.resp = resp;
        b.last = last;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic score(input int ch, input beat_t act);
        beat_t exp;
        n_cmp++;
        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL r%0d_unexpected_beat: got id=%h data=%h, expected no beat", ch, act.id, act.data);
        end else begin
            exp = (ch == 0) ? q0.pop_front() : q1.pop_front();
            if (act !== exp) begin
                n_bad++;
                $display("FAIL r%0d_beat: got %h, expected %h", ch, act, exp);
            end else begin
                $display("r%0d pop id=%h user=%h data=%h resp=%b last=%b", ch,
                         act.id, act.user, act.data, act.resp, act.last);
            end
        end
    endtask

    // Capture accepted beats and check delivered ones; push first so a same-cycle bypass finds its entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid0 && s_ready0) q0.push_back(b0);
            if (s_valid1 && s_ready1) q1.push_back(b1);
            if (m_valid0 && m_ready0) score(0, act0);
            if (m_valid1 && m_ready1) score(1, act1);
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int ch);
        bit done = 1'b0;
        if (ch == 0) begin m_ready0 = 1'b1; s_valid0 = 1'b0; end
        else         begin m_ready1 = 1'b1; s_valid1 = 1'b0; end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if ((ch == 0) ? !m_valid0 : !m_valid1) done = 1'b1;
            cyc;
        end
        check($sformatf("drain%0d_timeout", ch), {63'd0, !done}, 64'd0);
    endtask

    initial begin
        int exp_b_fill[4];
        int exp_b_drain[4];
        int exp_e_drain[4];
        bit acc;
        int tries;

        rst_n = 1'b0;
        s_valid0 = 1'b0; m_ready0 = 1'b0; b0 = '0;
        s_valid1 = 1'b0; m_ready1 = 1'b0; b1 = '0;
        repeat (2) cyc;
        @(negedge clk);
        check("rst_valid", m_valid0, 0);
        check("rst_level", level0, 0);
        check("rst_bursts", bursts0, 0);
        check("rst_err", err0, 0);
        #2 rst_n = 1'b1;
        cyc;
        @(negedge clk);
        check("ready_after_reset", s_ready0, 1);
        cyc;

        // Fill to DEPTH with downstream stalled.
        for (int i = 0; i < 4; i++) begin
            b0 = mk(4'(i), 64'hA0 + 64'(i), RESP_OKAY, i == 3);
            s_valid0 = 1'b1;
            cyc;
        end
        b0 = mk(4'd4, 64'hA4, RESP_OKAY, 1'b0);
        @(negedge clk);
        check("full_level", level0, 4);
        check("full_ready", s_ready0, 0);
        check("full_valid", m_valid0, 1);
        check("full_bursts", bursts0, 1);
        cyc;
        @(negedge clk);
        check("no_fifth_level", level0, 4);
        cyc;
        m_ready0 = 1'b1;
        @(negedge clk);
        check("full_pop_ready", s_ready0, 0);
        cyc;
        s_valid0 = 1'b0;
        @(negedge clk);
        check("full_pop_level", level0, 3);
        check("after_pop_ready", s_ready0, 1);
        cyc;
        drain(0);
        check("drain_level", level0, 0);
        check("drain_bursts", bursts0, 0);

        // Continuous streaming, one beat per cycle.
        m_ready0 = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            b0 = mk(4'(i), 64'(i), RESP_OKAY, (i % 8) == 0);
            s_valid0 = 1'b1;
            if (i == 10 || i == 20) begin
                @(negedge clk);
                check($sformatf("stream_level_%0d", i), level0, 1);
            end
            cyc;
        end
        s_valid0 = 1'b0;
        drain(0);
        check("stream_bursts", bursts0, 0);

        // Two 2-beat bursts, the third beat carries SLVERR.
        exp_b_fill  = '{0, 0, 1, 1};
        exp_b_drain = '{2, 2, 1, 1};
        exp_e_drain = '{0, 0, 0, 1};
        m_ready0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b0 = mk(4'(8 + i), 64'hB000 + 64'(i), (i == 2) ? RESP_SLVERR : RESP_OKAY, (i % 2) == 1);
            s_valid0 = 1'b1;
            @(negedge clk);
            check($sformatf("fill_bursts_%0d", i), bursts0, 64'(exp_b_fill[i]));
            cyc;
        end
        s_valid0 = 1'b0;
        @(negedge clk);
        check("burst_full_bursts", bursts0, 2);
        check("burst_full_level", level0, 4);
        cyc;
        m_ready0 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("drain_bursts_%0d", j), bursts0, 64'(exp_b_drain[j]));
            check($sformatf("drain_err_%0d", j), err0, 64'(exp_e_drain[j]));
            cyc;
        end
        @(negedge clk);
        check("burst_empty_bursts", bursts0, 0);
        check("burst_empty_valid", m_valid0, 0);
        cyc;
        repeat (3) cyc;
        @(negedge clk);
        check("err_sticky", err0, 1);
        cyc;

        // Reset while holding three beats.
        m_ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b0 = mk(4'(i), 64'hC0 + 64'(i), RESP_OKAY, i == 2);
            s_valid0 = 1'b1;
            cyc;
        end
        s_valid0 = 1'b0;
        @(negedge clk);
        check("pre_reset_level", level0, 3);
        check("pre_reset_bursts", bursts0, 1);
        #2 rst_n = 1'b0;
        q0.delete();
        #1;
        check("midrst_valid", m_valid0, 0);
        check("midrst_level", level0, 0);
        check("midrst_bursts", bursts0, 0);
        check("midrst_err", err0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", s_ready0, 1);
        check("postrst_valid", m_valid0, 0);
        cyc;
        b0 = mk(4'd9, 64'hDEAD_BEEF_0123_4567, RESP_EXOKAY, 1'b1);
        s_valid0 = 1'b1;
        cyc;
        s_valid0 = 1'b0;
        drain(0);

        // Fall-through instance: empty FIFO forwards in the same cycle.
        m_ready1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b1 = mk(4'(i + 1), 64'h100 + 64'(i), RESP_OKAY, i == 4);
            s_valid1 = 1'b1;
            @(negedge clk);
            check($sformatf("ft_valid_%0d", i), m_valid1, 1);
            check($sformatf("ft_level_%0d", i), level1, 0);
            cyc;
        end
        s_valid1 = 1'b0;
        @(negedge clk);
        check("ft_bursts", bursts1, 0);
        check("ft_idle_valid", m_valid1, 0);
        cyc;

        // DEPTH=3 with random downstream stalls, exercising pointer wrap.
        for (int i = 0; i < 10; i++) begin
            b1 = mk(4'(i), 64'h200 + 64'(i), (i == 6) ? RESP_SLVERR : RESP_OKAY, (i % 3) == 2);
            s_valid1 = 1'b1;
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 50) begin
                m_ready1 = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = s_ready1;
                tries++;
                cyc;
            end
            check($sformatf("stall_accept_timeout_%0d", i), {63'd0, !acc}, 64'd0);
        end
        s_valid1 = 1'b0;
        drain(1);
        check("stall_level", level1, 0);
        check("stall_bursts", bursts1, 0);
        check("stall_err", err1, 1);

        check("q0_leftover", 64'(q0.size()), 0);
        check("q1_leftover", 64'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
